// File: rtl/sub_64bit_pipe_pkg.sv
// Shared widths and the generate/propagate combine cell for the pipelined subtractor.
package sub_64bit_pipe_pkg;

  localparam int unsigned SUB_WIDTH = 64;
  localparam int unsigned SUB_SPLIT = 32;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Combine a more-significant group (hi) with a less-significant group (lo).
  function automatic gp_t cla_gen_prop(input gp_t hi, input gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

endpackage

// File: rtl/sub_64bit_pipe_cla_slice.sv
// N-bit carry-lookahead adder slice: parallel-prefix generate/propagate tree with carry-in.
module sub_64bit_pipe_cla_slice
  import sub_64bit_pipe_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int LVLS = (N > 1) ? $clog2(N) : 1;

  gp_t gp_bit [N];
  gp_t gp_pre [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      gp_bit[i].g = a[i] & b[i];
      gp_bit[i].p = a[i] ^ b[i];
    end
    gp_pre = gp_bit;
    // Fold the carry-in into bit 0 so every prefix already includes it.
    gp_pre[0].g = gp_bit[0].g | (gp_bit[0].p & cin);
    // Descending index keeps gp_pre[i - span] at its previous-level value.
    for (int l = 0; l < LVLS; l++) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (i >= (1 << l)) begin
          gp_pre[i] = cla_gen_prop(gp_pre[i], gp_pre[i - (1 << l)]);
        end
      end
    end
    sum    = '0;
    sum[0] = gp_bit[0].p ^ cin;
    for (int i = 1; i < N; i++) begin
      sum[i] = gp_bit[i].p ^ gp_pre[i-1].g;
    end
    cout = gp_pre[N-1].g;
  end

endmodule

// File: rtl/sub_64bit_pipe.sv
// Two-stage pipelined subtractor D = A - B - borrow_in, computed as A + ~B + ~borrow_in,
// with valid/ready handshaking on both sides; low half resolves in s1, high half in s2.
module sub_64bit_pipe
  import sub_64bit_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = SUB_WIDTH,
  parameter int unsigned SPLIT = SUB_SPLIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_borrow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_d,
  output logic             out_borrow,
  output logic             out_overflow
);

  localparam int unsigned HI_W = WIDTH - SPLIT;

  logic             vld_p1_q, vld_p1_d;
  logic [SPLIT-1:0] lo_p1_q, lo_p1_d;
  logic             clo_p1_q, clo_p1_d;
  logic [HI_W-1:0]  ahi_p1_q, ahi_p1_d;
  logic [HI_W-1:0]  bhi_p1_q, bhi_p1_d;

  logic             vld_p2_q, vld_p2_d;
  logic [WIDTH-1:0] d_p2_q, d_p2_d;
  logic             borrow_p2_q, borrow_p2_d;
  logic             ovf_p2_q, ovf_p2_d;

  logic [SPLIT-1:0] lo_sum;
  logic             lo_cout;
  logic [HI_W-1:0]  hi_sum;
  logic             hi_cout;
  logic             s2_adv;
  logic             accept;
  logic             s1_move;

  sub_64bit_pipe_cla_slice #(.N(SPLIT)) u_lo_slice (
    .a    (in_a[SPLIT-1:0]),
    .b    (~in_b[SPLIT-1:0]),
    .cin  (~in_borrow),
    .sum  (lo_sum),
    .cout (lo_cout)
  );

  sub_64bit_pipe_cla_slice #(.N(HI_W)) u_hi_slice (
    .a    (ahi_p1_q),
    .b    (~bhi_p1_q),
    .cin  (clo_p1_q),
    .sum  (hi_sum),
    .cout (hi_cout)
  );

  assign s2_adv   = ~vld_p2_q | out_ready;
  assign in_ready = ~vld_p1_q | s2_adv;
  assign accept   = in_valid & in_ready;
  assign s1_move  = vld_p1_q & s2_adv;

  always_comb begin
    vld_p1_d    = accept | (vld_p1_q & ~s2_adv);
    lo_p1_d     = lo_p1_q;
    clo_p1_d    = clo_p1_q;
    ahi_p1_d    = ahi_p1_q;
    bhi_p1_d    = bhi_p1_q;
    vld_p2_d    = s2_adv ? vld_p1_q : vld_p2_q;
    d_p2_d      = d_p2_q;
    borrow_p2_d = borrow_p2_q;
    ovf_p2_d    = ovf_p2_q;
    if (accept) begin
      lo_p1_d  = lo_sum;
      clo_p1_d = lo_cout;
      ahi_p1_d = in_a[WIDTH-1:SPLIT];
      bhi_p1_d = in_b[WIDTH-1:SPLIT];
    end
    if (s1_move) begin
      d_p2_d      = {hi_sum, lo_p1_q};
      borrow_p2_d = ~hi_cout;
      ovf_p2_d    = (ahi_p1_q[HI_W-1] ^ bhi_p1_q[HI_W-1]) & (hi_sum[HI_W-1] ^ ahi_p1_q[HI_W-1]);
    end
  end

  // Stage boundary s1: low-half sum and carry, raw upper operand halves.
  always_ff @(posedge clk) begin
    lo_p1_q  <= lo_p1_d;
    clo_p1_q <= clo_p1_d;
    ahi_p1_q <= ahi_p1_d;
    bhi_p1_q <= bhi_p1_d;
  end

  // Stage boundary s2: output registers, cleared by reset so outputs read zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      d_p2_q      <= '0;
      borrow_p2_q <= 1'b0;
      ovf_p2_q    <= 1'b0;
    end else begin
      vld_p1_q    <= vld_p1_d;
      vld_p2_q    <= vld_p2_d;
      d_p2_q      <= d_p2_d;
      borrow_p2_q <= borrow_p2_d;
      ovf_p2_q    <= ovf_p2_d;
    end
  end

  assign out_valid    = vld_p2_q;
  assign out_d        = d_p2_q;
  assign out_borrow   = borrow_p2_q;
  assign out_overflow = ovf_p2_q;

endmodule
